// File: rtl/fpro_uart_core.sv
// FPro MMIO UART slot: 16x-oversampling baud generator, 8N1 TX/RX state machines and TX/RX FIFOs.
// Optional sticky RX overrun flag is compiled in with `define UART_OVERRUN_EN.
module fpro_uart_core #(
  parameter int          DBIT      = 8,
  parameter int          SB_TICK   = 16,
  parameter int          FIFO_W    = 3,
  parameter logic [10:0] DVSR_INIT = 11'd650
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        rx,
  output logic        tx
);

  localparam int DEPTH = 2 ** FIFO_W;
  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0]    S_ONE       = 1;
  localparam logic [S_W-1:0]    S_MID       = 7;
  localparam logic [S_W-1:0]    S_BIT_LAST  = 15;
  localparam logic [S_W-1:0]    S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_ONE       = 1;
  localparam logic [N_W-1:0]    N_LAST      = N_W'(DBIT - 1);
  localparam logic [FIFO_W-1:0] PTR_ONE     = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // ---------------------------------------------------------------------------
  // Slot register decode
  // ---------------------------------------------------------------------------
  logic wr_en, wr_dvsr, wr_tx, rd_pop;

  assign wr_en   = cs & write;
  assign wr_dvsr = wr_en & (addr == 5'd1);
  assign wr_tx   = wr_en & (addr == 5'd2);
  assign rd_pop  = wr_en & (addr == 5'd3);

  logic unused_bus;
  assign unused_bus = ^{read, wr_data[31:11]};

  // ---------------------------------------------------------------------------
  // Baud generator: one tick every dvsr+1 clocks
  // ---------------------------------------------------------------------------
  logic [10:0] dvsr, baud_cnt;
  logic        tick;

  assign tick = (baud_cnt == dvsr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvsr     <= DVSR_INIT;
      baud_cnt <= '0;
    end else if (wr_dvsr) begin
      dvsr     <= wr_data[10:0];
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 11'd1;
    end
  end

  // rx is asynchronous to clk; idles high so reset to 1 to avoid a false start bit.
  logic rx_meta, rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFOs: index 0 = TX, index 1 = RX
  // ---------------------------------------------------------------------------
  logic            f_push  [2];
  logic            f_pop   [2];
  logic            f_full  [2];
  logic            f_empty [2];
  logic [DBIT-1:0] f_wdata [2];
  logic [DBIT-1:0] f_head  [2];

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr, rd_ptr;
    logic              full_r, empty_r;
    logic              do_push, do_pop;

    assign do_pop  = f_pop[i] & ~empty_r;
    assign do_push = f_push[i] & (~full_r | do_pop);

    // NOTE: storage has no reset; only pointers and flags need a known value, and the head is masked while empty.
    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= f_wdata[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        full_r  <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (do_push && !do_pop) begin
          empty_r <= 1'b0;
          full_r  <= (wr_ptr + PTR_ONE == rd_ptr);
        end else if (do_pop && !do_push) begin
          full_r  <= 1'b0;
          empty_r <= (rd_ptr + PTR_ONE == wr_ptr);
        end
      end
    end

    assign f_full[i]  = full_r;
    assign f_empty[i] = empty_r;
    assign f_head[i]  = empty_r ? '0 : mem[rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // RX state machine
  // ---------------------------------------------------------------------------
  uart_state_e     rx_state;
  logic [S_W-1:0]  rx_cnt;
  logic [N_W-1:0]  rx_n;
  logic [DBIT-1:0] rx_b;
  logic            rx_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        ST_IDLE:
          if (!rx_s) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        ST_START:
          if (tick) begin
            if (rx_cnt == S_MID) begin
              // Re-check mid start bit so a short low glitch does not start a frame.
              rx_state <= rx_s ? ST_IDLE : ST_DATA;
              rx_cnt   <= '0;
              rx_n     <= '0;
            end else begin
              rx_cnt <= rx_cnt + S_ONE;
            end
          end
        ST_DATA:
          if (tick) begin
            if (rx_cnt == S_BIT_LAST) begin
              rx_cnt <= '0;
              rx_b   <= {rx_s, rx_b[DBIT-1:1]};
              if (rx_n == N_LAST) rx_state <= ST_STOP;
              else                rx_n     <= rx_n + N_ONE;
            end else begin
              rx_cnt <= rx_cnt + S_ONE;
            end
          end
        ST_STOP:
          if (tick) begin
            if (rx_cnt == S_STOP_LAST) begin
              rx_push  <= 1'b1;
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt <= rx_cnt + S_ONE;
            end
          end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------------
  uart_state_e     tx_state;
  logic [S_W-1:0]  tx_cnt;
  logic [N_W-1:0]  tx_n;
  logic [DBIT-1:0] tx_b;
  logic            tx_reg;
  logic            tx_load;

  // Reloading straight from the end of the stop bit keeps back-to-back frames gap-free.
  assign tx_load = ~f_empty[0] &
                   ((tx_state == ST_IDLE) ||
                    ((tx_state == ST_STOP) && tick && (tx_cnt == S_STOP_LAST)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_reg   <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE:
          if (tx_load) begin
            tx_b     <= f_head[0];
            tx_reg   <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= ST_START;
          end
        ST_START:
          if (tick) begin
            if (tx_cnt == S_BIT_LAST) begin
              tx_cnt   <= '0;
              tx_n     <= '0;
              tx_reg   <= tx_b[0];
              tx_state <= ST_DATA;
            end else begin
              tx_cnt <= tx_cnt + S_ONE;
            end
          end
        ST_DATA:
          if (tick) begin
            if (tx_cnt == S_BIT_LAST) begin
              tx_cnt <= '0;
              if (tx_n == N_LAST) begin
                tx_reg   <= 1'b1;
                tx_state <= ST_STOP;
              end else begin
                tx_n   <= tx_n + N_ONE;
                tx_b   <= tx_b >> 1;
                tx_reg <= tx_b[1];
              end
            end else begin
              tx_cnt <= tx_cnt + S_ONE;
            end
          end
        ST_STOP:
          if (tick) begin
            if (tx_cnt == S_STOP_LAST) begin
              tx_cnt <= '0;
              if (tx_load) begin
                tx_b     <= f_head[0];
                tx_reg   <= 1'b0;
                tx_state <= ST_START;
              end else begin
                tx_state <= ST_IDLE;
              end
            end else begin
              tx_cnt <= tx_cnt + S_ONE;
            end
          end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  assign tx = tx_reg;

  // ---------------------------------------------------------------------------
  // FIFO hookup, overrun flag and read mux
  // ---------------------------------------------------------------------------
  assign f_push[0]  = wr_tx;
  assign f_wdata[0] = DBIT'(wr_data[7:0]);
  assign f_pop[0]   = tx_load;
  assign f_push[1]  = rx_push;
  assign f_wdata[1] = rx_b;
  assign f_pop[1]   = rd_pop;

  logic ovr;

`ifdef UART_OVERRUN_EN
  logic wr_clr, rx_drop;

  assign wr_clr  = wr_en & (addr == 5'd4);
  assign rx_drop = rx_push & f_full[1] & ~rd_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovr <= 1'b0;
    else if (rx_drop) ovr <= 1'b1;
    else if (wr_clr)  ovr <= 1'b0;
  end
`else
  logic unused_rx_full;
  assign unused_rx_full = f_full[1];
  assign ovr            = 1'b0;
`endif

  logic [7:0] rx_byte;
  assign rx_byte = 8'(f_head[1]);

  // NOTE: default assignment first so the combinational read mux never infers a latch.
  always_comb begin
    rd_data = '0;
    if (addr == 5'd0) rd_data = {21'b0, ovr, f_full[0], f_empty[1], rx_byte};
  end

endmodule

// File: tb/tb_fpro_uart_core.sv
// Randomized self-checking bench for fpro_uart_core: line-level TX decoding plus a queue model of the RX FIFO.
module tb_fpro_uart_core;

`ifdef UART_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam int RX_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        rx, tx, rx_drv, loop_en;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic       ovr_m = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx = loop_en ? tx : rx_drv;

  fpro_uart_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rx      (rx),
    .tx      (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model of the RX FIFO as seen by firmware: bounded queue plus sticky overrun.
  function automatic void model_push(input logic [7:0] b);
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else if (OVR_EN)            ovr_m = 1'b1;
  endfunction

  function automatic logic [31:0] model_status(input logic tx_full_exp);
    logic [7:0] head;
    head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    return {21'b0, ovr_m, tx_full_exp, rx_q.size() == 0, head};
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 v = rd_data;
    cs = 1'b0; read = 1'b0; addr = '0;
  endtask

  task automatic check_status(input string tag, input logic tx_full_exp);
    logic [31:0] v;
    read_reg(5'd0, v);
    check(tag, v, model_status(tx_full_exp));
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int limit);
    bit seen = 1'b0;
    read = 1'b1; addr = '0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      #1 if (!rd_data[8]) seen = 1'b1;
    end
    read = 1'b0;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Bench-side 8N1 transmitter at 16 clk per bit (dvsr = 0).
  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      rx_drv = fr[j];
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    logic all_high;
    all_high = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) all_high = 1'b0;
    end
    check(tag, all_high, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  fr;
    logic [9:0]  obs;
    logic [15:0] samp;
    logic [7:0]  b;
    logic [7:0]  tq [10];
    int          w, s, d, a;
    bit          found;

    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; rx_drv = 1'b1; loop_en = 1'b0;

    // Reset values, visible while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("t1_tx_in_reset", tx, 1'b1);
    check("t1_status_in_reset", rd_data, 32'h100);
    read_reg(5'd5, v);
    check("t1_unmapped_read", v, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_status("t1_status_after_reset", 1'b0);

    // Single frame 0x55 at dvsr = 0: exact waveform.
    bus_write(5'd1, 32'd0);
    bus_write(5'd2, 32'h55);
    w = cyc;
    found = 1'b0;
    s = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (!tx) begin found = 1'b1; s = cyc; end
    end
    check("t2_start_within_2clk", found && (s - w <= 2), 1'b1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 16; c++) begin
        samp[c] = tx;
        @(negedge clk);
      end
      check($sformatf("t2_bit%0d", j), samp, {16{fr[j]}});
    end
    check_idle("t2_idle_after_frame", 20);

    // Loopback: directed 0xA5 then random bytes.
    loop_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      bus_write(5'd2, {24'h0, b});
      wait_rx($sformatf("t3_loop%0d", k), 170);
      model_push(b);
      check_status($sformatf("t3_loop%0d_head", k), 1'b0);
      bus_write(5'd3, 32'h0);
      void'(rx_q.pop_front());
      check_status($sformatf("t3_loop%0d_popped", k), 1'b0);
    end
    repeat (200) @(negedge clk);
    loop_en = 1'b0;

    // TX FIFO fill at dvsr = 650, then speed up the line to decode the queued frames.
    bus_write(5'd1, 32'd650);
    for (int k = 0; k < 10; k++) tq[k] = 8'($urandom);
    for (int k = 0; k < 9; k++) bus_write(5'd2, {24'h0, tq[k]});
    read_reg(5'd0, v);
    check("t4_full_after9", v[9], 1'b1);
    bus_write(5'd2, {24'h0, tq[9]});
    read_reg(5'd0, v);
    check("t4_full_after10", v[9], 1'b1);
    bus_write(5'd1, 32'd0);
    d = cyc;
    a = d + 16;
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 10; j++) begin
        wait_until(a - 16 + k * 160 + j * 16 + 8);
        obs[j] = tx;
      end
      check($sformatf("t4_frame%0d", k), obs, {1'b1, tq[k], 1'b0});
    end
    wait_until(a - 16 + 9 * 160);
    check_idle("t4_no_tenth_frame", 300);

    // Short low glitch on rx must not produce a byte.
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_status("t5_glitch_no_push", 1'b0);

    // Nine frames with no pops: eight kept, ninth dropped.
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      send_rx(b);
      model_push(b);
    end
    repeat (8) @(negedge clk);
    check_status("t6_full_rx_fifo", 1'b0);
    bus_write(5'd4, 32'h0);
    ovr_m = 1'b0;
    check_status("t6_ovr_cleared", 1'b0);
    for (int k = 0; k < RX_DEPTH; k++) begin
      check_status($sformatf("t6_pop%0d", k), 1'b0);
      bus_write(5'd3, 32'h0);
      void'(rx_q.pop_front());
    end
    check_status("t6_drained", 1'b0);
    bus_write(5'd3, 32'h0);
    check_status("t6_pop_on_empty", 1'b0);

    // Reset in the middle of a frame forces tx high immediately.
    bus_write(5'd2, 32'h00);
    repeat (40) @(negedge clk);
    check("t7_tx_low_midframe", tx, 1'b0);
    #3 reset_n = 1'b0;
    #1 check("t7_tx_async_high", tx, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("t7_idle_after_reset", 200);
    check_status("t7_status_after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
